// File: rtl/wash_cycle_seq_pkg.sv
// Shared definitions for the wash cycle sequencer: state codes, program
// codes and the phase-duration helper.
package wash_pkg;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_FILL  = 4'd1;
  localparam logic [3:0] ST_WASH  = 4'd2;
  localparam logic [3:0] ST_DRAIN = 4'd3;
  localparam logic [3:0] ST_RINSE = 4'd4;
  localparam logic [3:0] ST_SPIN  = 4'd5;
  localparam logic [3:0] ST_DONE  = 4'd6;
  localparam logic [3:0] ST_PAUSE = 4'd7;
  localparam logic [3:0] ST_ERROR = 4'd8;

  typedef enum logic [3:0] {
    S_IDLE  = ST_IDLE,
    S_FILL  = ST_FILL,
    S_WASH  = ST_WASH,
    S_DRAIN = ST_DRAIN,
    S_RINSE = ST_RINSE,
    S_SPIN  = ST_SPIN,
    S_DONE  = ST_DONE,
    S_PAUSE = ST_PAUSE,
    S_ERROR = ST_ERROR
  } state_e;

  localparam logic [1:0] PROG_QUICK  = 2'd0;
  localparam logic [1:0] PROG_NORMAL = 2'd1;
  localparam logic [1:0] PROG_HEAVY  = 2'd2;
  localparam logic [1:0] PROG_RINSE  = 2'd3;

  // Cycles spent in a phase; for FILL/DRAIN this is the level timeout.
  function automatic int phase_dur(state_e s, logic [1:0] prog,
                                   int wash_t, int rinse_t, int spin_t, int tmo_t);
    case (s)
      S_FILL, S_DRAIN: phase_dur = tmo_t;
      S_WASH:          phase_dur = wash_t * (int'(prog) + 1);
      S_RINSE:         phase_dur = rinse_t;
      S_SPIN:          phase_dur = spin_t;
      default:         phase_dur = 0;
    endcase
  endfunction

endpackage

// File: rtl/wash_cycle_seq_if.sv
// Front-panel / sensor inputs and actuator / status outputs of the sequencer.
interface wash_cycle_seq_if #(parameter int TIMER_W = 16);
  logic               start;
  logic [1:0]         program_sel;
  logic               pause_req;
  logic               resume_req;
  logic               door_closed;
  logic               level_full;
  logic               level_empty;
  logic               valve_cold;
  logic               valve_hot;
  logic               valve_out;
  logic               motor;
  logic               motor_spin;
  logic [3:0]         phase;
  logic [TIMER_W-1:0] remaining;
  logic               busy;
  logic               done;
  logic               error;

  modport master (
    output start, program_sel, pause_req, resume_req, door_closed,
           level_full, level_empty,
    input  valve_cold, valve_hot, valve_out, motor, motor_spin,
           phase, remaining, busy, done, error
  );

  modport slave (
    input  start, program_sel, pause_req, resume_req, door_closed,
           level_full, level_empty,
    output valve_cold, valve_hot, valve_out, motor, motor_spin,
           phase, remaining, busy, done, error
  );
endinterface

// File: rtl/wash_cycle_seq_phase_timer.sv
// Loadable down-counter; stops at zero, load has priority over counting.
module phase_timer #(
  parameter int TIMER_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  input  logic               en_i,
  output logic [TIMER_W-1:0] cnt_o,
  output logic               zero_o
);
  logic [TIMER_W-1:0] cnt_q;

  // Load a fresh duration on phase entry, otherwise count down while enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      cnt_q <= '0;
    else if (load_i)              cnt_q <= load_val_i;
    else if (en_i && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/wash_cycle_seq.sv
// Washing-machine cycle sequencer: FILL/WASH/DRAIN, rinse loops, SPIN,
// with pause/resume and level timeouts.
module wash_cycle_seq
  import wash_pkg::*;
#(
  parameter int TIMER_W     = 16,
  parameter int WASH_TICKS  = 100,
  parameter int RINSE_TICKS = 60,
  parameter int SPIN_TICKS  = 40,
  parameter int RINSE_CNT   = 2,
  parameter int LEVEL_TMO   = 200
) (
  input  logic            clk,
  input  logic            rst,
  wash_cycle_seq_if.slave bus
);
  // The heavy wash (3x base) must fit in the phase timer.
  if (64'(3 * WASH_TICKS) >= (64'd1 << TIMER_W)) begin : g_tmr_chk
    $error("TIMER_W too narrow for 3*WASH_TICKS");
  end

  localparam logic [2:0] RC = 3'(RINSE_CNT);

  state_e             state_q, state_d, saved_q, saved_d;
  logic [2:0]         rinse_q, rinse_d;
  logic [1:0]         prog_q, prog_d;
  logic               run, hold, tmr_ld, tmr_en, tmr_zero;
  logic [TIMER_W-1:0] tmr_val, tmr_cnt;

  // Control registers; async reset returns straight to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      saved_q <= S_IDLE;
      rinse_q <= '0;
      prog_q  <= PROG_QUICK;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      rinse_q <= rinse_d;
      prog_q  <= prog_d;
    end
  end

  // Next state: pause overrides every running-state transition, including
  // one due in the same cycle the timer hits zero.
  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    rinse_d = rinse_q;
    prog_d  = prog_q;
    run  = state_q inside {S_FILL, S_WASH, S_DRAIN, S_RINSE, S_SPIN};
    hold = run && (bus.pause_req || !bus.door_closed);
    case (state_q)
      S_IDLE:
        if (bus.start && bus.door_closed) begin
          state_d = S_FILL;
          prog_d  = bus.program_sel;
          rinse_d = '0;
        end
      S_FILL:
        if (bus.level_full)
          state_d = (rinse_q != '0 || prog_q == PROG_RINSE) ? S_RINSE : S_WASH;
        else if (tmr_zero)
          state_d = S_ERROR;
      S_WASH, S_RINSE:
        if (tmr_zero) state_d = S_DRAIN;
      S_DRAIN:
        if (bus.level_empty) begin
          if (rinse_q < RC) begin
            rinse_d = rinse_q + 3'd1;
            state_d = S_FILL;
          end else begin
            state_d = S_SPIN;
          end
        end else if (tmr_zero) begin
          state_d = S_ERROR;
        end
      S_SPIN:  if (tmr_zero) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_PAUSE: if (bus.resume_req && bus.door_closed) state_d = saved_q;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
    if (hold) begin
      state_d = S_PAUSE;
      saved_d = state_q;
      rinse_d = rinse_q;
    end
  end

  // Reload on entry to a fresh phase, never on return from PAUSE.
  always_comb begin
    tmr_ld  = (state_q != S_PAUSE) && (state_d != state_q) &&
              (state_d inside {S_FILL, S_WASH, S_DRAIN, S_RINSE, S_SPIN});
    tmr_val = TIMER_W'(phase_dur(state_d, prog_d, WASH_TICKS, RINSE_TICKS,
                                 SPIN_TICKS, LEVEL_TMO) - 1);
    tmr_en  = run && !hold;
  end

  phase_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (tmr_ld),
    .load_val_i(tmr_val),
    .en_i      (tmr_en),
    .cnt_o     (tmr_cnt),
    .zero_o    (tmr_zero)
  );

  // Moore output decode from registered state.
  always_comb begin
    bus.valve_cold = 1'b0;
    bus.valve_hot  = 1'b0;
    bus.valve_out  = 1'b0;
    bus.motor      = 1'b0;
    bus.motor_spin = 1'b0;
    case (state_q)
      S_FILL:
        if (prog_q == PROG_HEAVY && rinse_q == '0) bus.valve_hot  = 1'b1;
        else                                       bus.valve_cold = 1'b1;
      S_WASH, S_RINSE: bus.motor = 1'b1;
      S_DRAIN:         bus.valve_out = 1'b1;
      S_SPIN: begin
        bus.valve_out  = 1'b1;
        bus.motor_spin = 1'b1;
      end
      default: ;
    endcase
    bus.phase     = state_q;
    bus.remaining = tmr_cnt;
    bus.busy      = !(state_q inside {S_IDLE, S_DONE, S_ERROR});
    bus.done      = (state_q == S_DONE);
    bus.error     = (state_q == S_ERROR);
  end
endmodule

// File: tb/tb_wash_cycle_seq.sv
// Randomized bench for wash_cycle_seq against a plan-driven reference model.
module tb_wash_cycle_seq;
  import wash_pkg::*;

  localparam int TW = 16, P_WT = 4, P_RT = 3, P_ST = 5, P_RC = 2, P_TMO = 8;
  localparam int NCYC = 4000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wash_cycle_seq_if #(.TIMER_W(TW)) bus();

  wash_cycle_seq #(
    .TIMER_W(TW), .WASH_TICKS(P_WT), .RINSE_TICKS(P_RT),
    .SPIN_TICKS(P_ST), .RINSE_CNT(P_RC), .LEVEL_TMO(P_TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a cycle is a precomputed list of phases; the model walks
  // that list with a countdown, a pause flag and a terminal mode.
  typedef enum {K_FILL, K_WASH, K_DRAIN, K_RINSE, K_SPIN} kind_e;
  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE, M_ERR} mode_e;

  kind_e plan_k[$];
  int    plan_d[$];
  bit    plan_hot[$];
  mode_e mode = M_IDLE;
  int    idx = 0, rem = 0;
  bit    sens_on = 1'b1;

  task automatic push(input kind_e k, input int d, input bit h);
    plan_k.push_back(k);
    plan_d.push_back(d);
    plan_hot.push_back(h);
  endtask

  task automatic build(input int prog);
    plan_k.delete(); plan_d.delete(); plan_hot.delete();
    push(K_FILL, P_TMO, prog == 2);
    if (prog == 3) push(K_RINSE, P_RT, 1'b0);
    else           push(K_WASH, P_WT * (prog + 1), 1'b0);
    push(K_DRAIN, P_TMO, 1'b0);
    repeat (P_RC) begin
      push(K_FILL, P_TMO, 1'b0);
      push(K_RINSE, P_RT, 1'b0);
      push(K_DRAIN, P_TMO, 1'b0);
    end
    push(K_SPIN, P_ST, 1'b0);
  endtask

  task automatic advance();
    idx++;
    if (idx == plan_k.size()) mode = M_DONE;
    else                      rem  = plan_d[idx] - 1;
  endtask

  task automatic step(input bit st, input int ps, input bit pr, input bit rs,
                      input bit dc, input bit lf, input bit le);
    case (mode)
      M_IDLE:
        if (st && dc) begin
          build(ps); idx = 0; rem = P_TMO - 1; mode = M_RUN;
        end
      M_RUN:
        if (pr || !dc) mode = M_PAUSE;
        else if (plan_k[idx] == K_FILL || plan_k[idx] == K_DRAIN) begin
          if ((plan_k[idx] == K_FILL && lf) || (plan_k[idx] == K_DRAIN && le)) advance();
          else if (rem == 0) mode = M_ERR;
          else rem--;
        end else if (rem == 0) advance();
        else rem--;
      M_PAUSE: if (rs && dc) mode = M_RUN;
      M_DONE:  mode = M_IDLE;
      default: ;
    endcase
  endtask

  function automatic logic [3:0] exp_phase();
    case (mode)
      M_IDLE:  return ST_IDLE;
      M_PAUSE: return ST_PAUSE;
      M_DONE:  return ST_DONE;
      M_ERR:   return ST_ERROR;
      default:
        case (plan_k[idx])
          K_FILL:  return ST_FILL;
          K_WASH:  return ST_WASH;
          K_DRAIN: return ST_DRAIN;
          K_RINSE: return ST_RINSE;
          default: return ST_SPIN;
        endcase
    endcase
  endfunction

  // {cold, hot, out, motor, spin, busy, done, error}
  function automatic logic [7:0] exp_vec();
    case (mode)
      M_IDLE:  return 8'b0000_0000;
      M_PAUSE: return 8'b0000_0100;
      M_DONE:  return 8'b0000_0010;
      M_ERR:   return 8'b0000_0001;
      default:
        case (plan_k[idx])
          K_FILL:  return plan_hot[idx] ? 8'b0100_0100 : 8'b1000_0100;
          K_WASH,
          K_RINSE: return 8'b0001_0100;
          K_DRAIN: return 8'b0010_0100;
          default: return 8'b0010_1100;
        endcase
    endcase
  endfunction

  task automatic compare(input string tag);
    chk({tag, ".phase"}, 32'(bus.phase), 32'(exp_phase()));
    chk({tag, ".remaining"}, 32'(bus.remaining), rem);
    chk({tag, ".outs"},
        32'({bus.valve_cold, bus.valve_hot, bus.valve_out, bus.motor,
             bus.motor_spin, bus.busy, bus.done, bus.error}),
        32'(exp_vec()));
  endtask

  initial begin
    bus.start = 1'b0; bus.program_sel = 2'd0; bus.pause_req = 1'b0;
    bus.resume_req = 1'b0; bus.door_closed = 1'b1;
    bus.level_full = 1'b0; bus.level_empty = 1'b0;
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    compare("reset");
    rst = 1'b0;

    repeat (NCYC) begin
      if (mode == M_IDLE) sens_on = ($urandom % 8) != 0;
      bus.start       = ($urandom % 3) == 0;
      bus.program_sel = 2'($urandom);
      bus.pause_req   = ($urandom % 14) == 0;
      bus.resume_req  = ($urandom % 3) == 0;
      bus.door_closed = ($urandom % 16) != 0;
      bus.level_full  = sens_on && (($urandom % 2) == 1);
      bus.level_empty = sens_on && (($urandom % 2) == 1);
      step(bus.start, int'(bus.program_sel), bus.pause_req, bus.resume_req,
           bus.door_closed, bus.level_full, bus.level_empty);
      @(negedge clk);
      compare("run");
      if ((mode == M_ERR && ($urandom % 6) == 0) || ($urandom % 400) == 0) begin
        rst = 1'b1;
        #1;
        mode = M_IDLE; rem = 0;
        compare("arst");
        @(negedge clk);
        compare("rsthold");
        rst = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
